// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard unit: forward selects, multiplier FSM states, MIPS opcodes.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WDOG_W = 8;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'd0,
        MULT_BUSY = 2'd1,
        MULT_DONE = 2'd2
    } mult_state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/hazard_mult_tracker.sv
// Multi-cycle multiplier tracker: IDLE/BUSY/DONE FSM, latency counter and per-register busy bits.
module hazard_mult_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned MULT_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue,
    input  logic [REG_W-1:0]      dest,
    output logic [2**REG_W-1:0]   busy,
    output logic                  busy_phase,
    output logic                  mult_busy,
    output logic                  mult_done
);

    localparam int unsigned NREG = 2**REG_W;

    mult_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REG_W-1:0]  dest_q, dest_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              done_q, done_d;

    // State, counter, destination and busy-vector registers; reset abandons any multiply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MULT_IDLE;
            cnt_q   <= '0;
            dest_q  <= '0;
            busy_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dest_q  <= dest_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state: count down in BUSY, release the destination in DONE; a new issue overrides (set wins).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dest_d  = dest_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            MULT_IDLE: ;
            MULT_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(2)) begin
                    state_d = MULT_DONE;
                end
            end
            MULT_DONE: begin
                busy_d[dest_q] = 1'b0;
                cnt_d          = '0;
                state_d        = MULT_IDLE;
            end
            default: state_d = MULT_IDLE;
        endcase
        if (issue && (state_q != MULT_BUSY)) begin
            state_d = MULT_BUSY;
            cnt_d   = CNT_W'(MULT_LAT - 1);
            dest_d  = dest;
            if (dest != '0) begin
                busy_d[dest] = 1'b1;
            end
        end
        done_d = (state_d == MULT_DONE);
    end

    assign busy       = busy_q;
    assign busy_phase = (state_q == MULT_BUSY);
    assign mult_busy  = (state_q != MULT_IDLE);
    assign mult_done  = done_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// 5-stage MIPS hazard unit: forwarding, load-use/branch stalls, multiply scoreboard.
// Optional stall watchdog enabled with `define HAZARD_WATCHDOG_EN.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned MULT_LAT   = 4,
    parameter int unsigned WDOG_LIMIT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rtE,
    input  logic [REG_W-1:0] WriteRegE,
    input  logic [REG_W-1:0] WriteRegM,
    input  logic [REG_W-1:0] WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             BranchD,
    input  logic             JumpD,
    input  logic             start_multD,
    input  logic [REG_W-1:0] mult_destD,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             mult_busy,
    output logic             mult_done,
    output logic             stall_timeout
);

    localparam int unsigned NREG = 2**REG_W;

    if ((MULT_LAT < 2) || (MULT_LAT > 15)) begin : g_bad_lat
        $error("hazard_scoreboard: MULT_LAT must be 2..15");
    end
    if ((WDOG_LIMIT < 2) || (WDOG_LIMIT > 255)) begin : g_bad_wdog
        $error("hazard_scoreboard: WDOG_LIMIT must be 2..255");
    end

    logic [NREG-1:0] busy;
    logic            busy_phase;
    logic            lwstall, branchstall, sbstall, multstall, stall;

    // E-stage forwarding (M over W) and D-stage branch-comparator forwarding from M.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if ((rsE != '0) && (rsE == WriteRegM) && RegWriteM)      ForwardAE = FWD_M;
        else if ((rsE != '0) && (rsE == WriteRegW) && RegWriteW) ForwardAE = FWD_W;
        if ((rtE != '0) && (rtE == WriteRegM) && RegWriteM)      ForwardBE = FWD_M;
        else if ((rtE != '0) && (rtE == WriteRegW) && RegWriteW) ForwardBE = FWD_W;
        ForwardAD = (rsD != '0) && (rsD == WriteRegM) && RegWriteM;
        ForwardBD = (rtD != '0) && (rtD == WriteRegM) && RegWriteM;
    end

    // Stall sources; a multiply or branch in D only reads rt through the scoreboard.
    always_comb begin
        lwstall     = MemtoRegE && (WriteRegE != '0) &&
                      ((WriteRegE == rsD) || (WriteRegE == rtD));
        branchstall = BranchD &&
                      ((RegWriteE && (WriteRegE != '0) &&
                        ((WriteRegE == rsD) || (WriteRegE == rtD))) ||
                       (MemtoRegM && (WriteRegM != '0) &&
                        ((WriteRegM == rsD) || (WriteRegM == rtD))));
        sbstall     = busy[rtD] || (!(start_multD || BranchD) && busy[rsD]);
        multstall   = start_multD && busy_phase;
        stall       = lwstall || branchstall || sbstall || multstall;
        StallF      = stall;
        StallD      = stall;
        FlushE      = stall;
        FlushD      = JumpD && !stall;
    end

    hazard_mult_tracker #(
        .REG_W    (REG_W),
        .MULT_LAT (MULT_LAT)
    ) u_mult (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (start_multD && !stall),
        .dest       (mult_destD),
        .busy       (busy),
        .busy_phase (busy_phase),
        .mult_busy  (mult_busy),
        .mult_done  (mult_done)
    );

`ifdef HAZARD_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog_cnt;
    logic              timeout_q;

    // Saturating run-length of consecutive stall cycles; sticky flag once the limit is hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (stall) begin
            if (wdog_cnt < WDOG_W'(WDOG_LIMIT)) begin
                wdog_cnt <= wdog_cnt + WDOG_W'(1);
            end
            if (wdog_cnt >= WDOG_W'(WDOG_LIMIT - 1)) begin
                timeout_q <= 1'b1;
            end
        end else begin
            wdog_cnt <= '0;
        end
    end

    assign stall_timeout = timeout_q;
`else
    assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard against a cycle-window reference model.
module tb_hazard_scoreboard;

    localparam int L    = 4;
    localparam int WDOG = 8;
`ifdef HAZARD_WATCHDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    logic       clk, rst_n;
    logic [4:0] rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW, mult_destD;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, JumpD, start_multD;
    logic       StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, mult_busy, mult_done, stall_timeout;
    logic [1:0] ForwardAE, ForwardBE;

    int checks = 0;
    int errors = 0;

    // model state: cycle index, issue cycle of the current multiply, its destination, watchdog
    int         cyc = 0;
    int         iss = -1;
    logic [4:0] m_dest = '0;
    int         run = 0;
    logic       m_to = 1'b0;

    hazard_scoreboard #(.REG_W(5), .MULT_LAT(L), .WDOG_LIMIT(WDOG)) dut (
        .clk(clk), .rst_n(rst_n), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD), .JumpD(JumpD),
        .start_multD(start_multD), .mult_destD(mult_destD),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .mult_busy(mult_busy), .mult_done(mult_done), .stall_timeout(stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded bound");
        $fatal(1);
    end

    function automatic logic [12:0] dut_vec();
        return {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
                ForwardAD, ForwardBD, mult_busy, mult_done, stall_timeout};
    endfunction

    // register r is pending from the issue cycle through the done cycle (L-1 cycles)
    function automatic logic m_busy(input logic [4:0] r);
        return (r != 5'd0) && (iss >= 0) && (r == m_dest) && (cyc >= iss) && (cyc <= iss + L - 2);
    endfunction

    function automatic logic m_in_busy();
        return (iss >= 0) && (cyc >= iss) && (cyc <= iss + L - 3);
    endfunction

    function automatic logic m_stall();
        logic lw, br, sb, ms;
        lw = MemtoRegE && (WriteRegE != 0) && ((WriteRegE == rsD) || (WriteRegE == rtD));
        br = BranchD && ((RegWriteE && (WriteRegE != 0) && ((WriteRegE == rsD) || (WriteRegE == rtD))) ||
                         (MemtoRegM && (WriteRegM != 0) && ((WriteRegM == rsD) || (WriteRegM == rtD))));
        sb = m_busy(rtD) || (!(start_multD || BranchD) && m_busy(rsD));
        ms = start_multD && m_in_busy();
        return lw || br || sb || ms;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] r);
        if ((r != 0) && (r == WriteRegM) && RegWriteM) return 2'b01;
        if ((r != 0) && (r == WriteRegW) && RegWriteW) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [12:0] exp_vec();
        logic s, md, mb;
        s  = m_stall();
        md = (iss >= 0) && (cyc == iss + L - 2);
        mb = m_in_busy() || md;
        return {s, s, JumpD && !s, s, m_fwd(rsE), m_fwd(rtE),
                (rsD != 0) && (rsD == WriteRegM) && RegWriteM,
                (rtD != 0) && (rtD == WriteRegM) && RegWriteM,
                mb, md, m_to};
    endfunction

    task automatic model_reset();
        iss = -1; run = 0; m_to = 1'b0;
    endtask

    task automatic clear_inputs();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0; WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; MemtoRegM = 0;
        BranchD = 0; JumpD = 0; start_multD = 0; mult_destD = 0;
    endtask

    // one clock edge, advancing the model with the inputs that were present before it
    task automatic advance();
        logic s, acc;
        s   = m_stall();
        acc = start_multD && !s;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (acc) begin iss = cyc; m_dest = mult_destD; end
            if (s) run++; else run = 0;
            if (WDOG_EN && (run >= WDOG)) m_to = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        advance();
        advance();
        #1;
        if (dut_vec() !== 13'd0) begin
            errors++; $display("FAIL reset_outputs: got %b want %b", dut_vec(), 13'd0);
        end
        checks++;
        rst_n = 1'b1;
        advance();
    endtask

    task automatic test_forward_e();
        clear_inputs();
        rsE = 3; rtE = 3; WriteRegM = 3; RegWriteM = 1; WriteRegW = 3; RegWriteW = 1;
        #1;
        if ({ForwardAE, ForwardBE} !== 4'b0101) begin
            errors++; $display("FAIL fwd_m_priority: got %b want %b", {ForwardAE, ForwardBE}, 4'b0101);
        end
        checks++;
        advance();
        RegWriteM = 0;
        #1;
        if ({ForwardAE, ForwardBE} !== 4'b1010) begin
            errors++; $display("FAIL fwd_w: got %b want %b", {ForwardAE, ForwardBE}, 4'b1010);
        end
        checks++;
        advance();
        rsE = 0; rtE = 0; WriteRegM = 0; RegWriteM = 1; WriteRegW = 0;
        #1;
        if (dut_vec() !== exp_vec() || ForwardAE !== 2'b00) begin
            errors++; $display("FAIL fwd_reg0: got %b want %b", dut_vec(), exp_vec());
        end
        checks++;
        advance();
    endtask

    task automatic test_lwstall();
        clear_inputs();
        MemtoRegE = 1; WriteRegE = 5; rtD = 5;
        #1;
        if ({StallF, StallD, FlushE} !== 3'b111) begin
            errors++; $display("FAIL lwstall: got %b want %b", {StallF, StallD, FlushE}, 3'b111);
        end
        checks++;
        advance();
        MemtoRegE = 0;
        #1;
        if (dut_vec() !== exp_vec() || StallD !== 1'b0) begin
            errors++; $display("FAIL lwstall_release: got %b want %b", dut_vec(), exp_vec());
        end
        checks++;
        MemtoRegE = 1; WriteRegE = 0; rtD = 0;
        #1;
        if (StallD !== 1'b0) begin
            errors++; $display("FAIL lwstall_reg0: got %b want %b", StallD, 1'b0);
        end
        checks++;
        advance();
    endtask

    task automatic test_branch();
        clear_inputs();
        BranchD = 1; rsD = 7; RegWriteE = 1; WriteRegE = 7;
        #1;
        if (StallD !== 1'b1 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL branchstall: got %b want %b", dut_vec(), exp_vec());
        end
        checks++;
        advance();
        RegWriteE = 0; WriteRegE = 0; WriteRegM = 7; RegWriteM = 1; MemtoRegM = 0;
        #1;
        if ({StallD, ForwardAD} !== 2'b01) begin
            errors++; $display("FAIL branch_fwd_ad: got %b want %b", {StallD, ForwardAD}, 2'b01);
        end
        checks++;
        advance();
        clear_inputs();
        JumpD = 1;
        #1;
        if ({FlushD, FlushE} !== 2'b10) begin
            errors++; $display("FAIL jump_flush: got %b want %b", {FlushD, FlushE}, 2'b10);
        end
        checks++;
        advance();
    endtask

    task automatic test_mult_reader();
        int n_stall, done_at, first_go;
        n_stall = 0; done_at = 0; first_go = 0;
        clear_inputs();
        start_multD = 1; mult_destD = 9;
        #1;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL mult_issue: got %b want %b", dut_vec(), exp_vec());
        end
        checks++;
        advance();
        start_multD = 0; rsD = 9;
        for (int i = 1; i <= 5; i++) begin
            #1;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL mult_reader_cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
            end
            checks++;
            if (StallD) n_stall++;
            else if (first_go == 0) first_go = i;
            if (mult_done) done_at = i;
            advance();
        end
        if (n_stall != L - 1 || done_at != L - 1 || first_go != L) begin
            errors++;
            $display("FAIL mult_reader_timing: got stalls=%0d done=%0d go=%0d want %0d %0d %0d",
                     n_stall, done_at, first_go, L - 1, L - 1, L);
        end
        checks++;
    endtask

    task automatic test_mult_back_to_back();
        int accept_at, done_seen;
        accept_at = 0; done_seen = 0;
        clear_inputs();
        start_multD = 1; mult_destD = 9;
        #1;
        advance();
        mult_destD = 10;
        for (int i = 1; i <= L - 1; i++) begin
            #1;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL b2b_cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
            end
            checks++;
            if (!StallD && accept_at == 0) accept_at = i;
            advance();
        end
        if (accept_at != L - 1) begin
            errors++; $display("FAIL b2b_accept: got %0d want %0d", accept_at, L - 1);
        end
        checks++;
        start_multD = 0; rtD = 10;
        #1;
        if ({StallD, mult_busy} !== 2'b11) begin
            errors++; $display("FAIL b2b_second_busy: got %b want %b", {StallD, mult_busy}, 2'b11);
        end
        checks++;
        rst_n = 1'b0;
        model_reset();
        #1;
        if ({StallD, mult_busy, mult_done} !== 3'b000) begin
            errors++; $display("FAIL reset_mid_busy: got %b want %b", {StallD, mult_busy, mult_done}, 3'b000);
        end
        checks++;
        advance();
        rst_n = 1'b1;
        for (int i = 0; i < L + 2; i++) begin
            #1;
            if (mult_done) done_seen++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL post_reset_cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
            end
            checks++;
            advance();
        end
        if (done_seen != 0) begin
            errors++; $display("FAIL abandoned_done: got %0d pulses want 0", done_seen);
        end
        checks++;
    endtask

    task automatic test_watchdog();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        advance();
        rst_n = 1'b1;
        MemtoRegE = 1; WriteRegE = 5; rtD = 5;
        for (int i = 0; i < WDOG; i++) begin
            #1;
            if (dut_vec() !== exp_vec() || stall_timeout !== 1'b0) begin
                errors++; $display("FAIL wdog_hold%0d: got %b want %b", i, dut_vec(), exp_vec());
            end
            checks++;
            advance();
        end
        MemtoRegE = 0;
        #1;
        if (stall_timeout !== WDOG_EN) begin
            errors++; $display("FAIL wdog_rise: got %b want %b", stall_timeout, WDOG_EN);
        end
        checks++;
        repeat (3) advance();
        #1;
        if (stall_timeout !== WDOG_EN || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL wdog_sticky: got %b want %b", dut_vec(), exp_vec());
        end
        checks++;
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        advance();
        rst_n = 1'b1;
        #1;
        if (stall_timeout !== 1'b0) begin
            errors++; $display("FAIL wdog_reset: got %b want 0", stall_timeout);
        end
        checks++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
            rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
            WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
            WriteRegW = 5'($urandom_range(0, 3)); mult_destD = 5'($urandom_range(0, 3));
            RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            MemtoRegE = ($urandom_range(0, 3) == 0); MemtoRegM = ($urandom_range(0, 3) == 0);
            BranchD = ($urandom_range(0, 3) == 0); JumpD = ($urandom_range(0, 3) == 0);
            start_multD = ($urandom_range(0, 3) == 0);
            #1;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL random_cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
            end
            checks++;
            advance();
        end
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_forward_e();
        test_lwstall();
        test_branch();
        test_mult_reader();
        test_mult_back_to_back();
        test_watchdog();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
